reg_file_mp: RTL and testbench



---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_init_fsm.sv | 57 +++++
 rtl/reg_file_mp.sv | 81 ++++++++
 tb/tb_reg_file_mp.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
package rf_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

  localparam int RF_INIT_ZERO  = 0;
  localparam int RF_INIT_INDEX = 1;

  // Widest XLEN supported; callers slice the low XLEN bits.
  localparam int RF_MAX_XLEN = 128;

  function automatic logic [RF_MAX_XLEN-1:0] rf_init_val(input logic [31:0] idx,
                                                         input int          mode);
    return (mode == RF_INIT_INDEX) ? RF_MAX_XLEN'(idx) : '0;
  endfunction

endpackage

// File: rtl/rf_init_fsm.sv
// Init engine: sweeps every register address once after reset or on request,
// then holds the file in RUN with ready asserted.
module rf_init_fsm
  import rf_pkg::*;
#(
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          init_req,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic          ready
);

  rf_state_t     state_q;
  logic [AW-1:0] init_cnt_q;
  logic          ready_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RF_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        RF_INIT: begin
          init_cnt_q <= init_cnt_q + AW'(1);
          if (init_cnt_q == AW'(NREGS - 1)) begin
            state_q <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN: begin
          if (init_req) begin
            state_q    <= RF_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= RF_INIT;
          init_cnt_q <= '0;
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

  assign init_we   = (state_q == RF_INIT) && !reset;
  assign init_addr = init_cnt_q;
  assign ready     = ready_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD combinational read ports, NWR write ports with
// highest-port-wins collisions, optional write-to-read bypass, hardwired reg 0.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter  int XLEN      = 64,
  parameter  int NREGS     = 32,
  parameter  int NRD       = 2,
  parameter  int NWR       = 2,
  parameter  int INIT_MODE = 1,
  parameter  int BYPASS    = 1,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                init_req,
  input  logic [NRD*AW-1:0]   read_reg,
  output logic [NRD*XLEN-1:0] read_data,
  input  logic [NWR*AW-1:0]   write_reg,
  input  logic [NWR*XLEN-1:0] write_data,
  input  logic [NWR-1:0]      regwrite,
  output logic                ready
);

  logic                   init_we;
  logic [AW-1:0]          init_addr;
  logic [RF_MAX_XLEN-1:0] init_val_full;
  logic [XLEN-1:0]        init_val;
  logic                   wr_commit;

  // NOTE: storage is deliberately left without a reset; the init engine
  // is the only thing that loads it, which keeps it a plain RAM array.
  logic [XLEN-1:0] mem [NREGS];

  rf_init_fsm #(.NREGS(NREGS)) u_init_fsm (
    .clock    (clock),
    .reset    (reset),
    .init_req (init_req),
    .init_we  (init_we),
    .init_addr(init_addr),
    .ready    (ready)
  );

  assign init_val_full = rf_init_val(32'(init_addr), INIT_MODE);
  assign init_val      = init_val_full[XLEN-1:0];

  // A RUN edge that also sees reset or init_req drops its port writes.
  assign wr_commit = ready && !reset && !init_req;

  // Ascending port order: the last non-blocking write to an address wins.
  always_ff @(posedge clock) begin
    if (init_we) begin
      mem[init_addr] <= init_val;
    end else if (wr_commit) begin
      for (int p = 0; p < NWR; p++) begin
        if (regwrite[p] && (write_reg[p*AW +: AW] != '0)) begin
          mem[write_reg[p*AW +: AW]] <= write_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // NOTE: read_data gets a full default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    read_data = '0;
    for (int k = 0; k < NRD; k++) begin
      if (ready && (read_reg[k*AW +: AW] != '0)) begin
        read_data[k*XLEN +: XLEN] = mem[read_reg[k*AW +: AW]];
        if (BYPASS != 0) begin
          for (int p = 0; p < NWR; p++) begin
            if (regwrite[p] && (write_reg[p*AW +: AW] == read_reg[k*AW +: AW])) begin
              read_data[k*XLEN +: XLEN] = write_data[p*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: directed scenarios plus random traffic
// checked against an array-based model of the register file.
module tb_reg_file_mp;

  localparam int XLEN      = 64;
  localparam int NREGS     = 32;
  localparam int NRD       = 2;
  localparam int NWR       = 2;
  localparam int INIT_MODE = 1;
  localparam int BYPASS    = 1;
  localparam int AW        = $clog2(NREGS);

  logic                clock = 1'b0;
  logic                reset;
  logic                init_req;
  logic [NRD*AW-1:0]   read_reg;
  logic [NRD*XLEN-1:0] read_data;
  logic [NWR*AW-1:0]   write_reg;
  logic [NWR*XLEN-1:0] write_data;
  logic [NWR-1:0]      regwrite;
  logic                ready;

  reg_file_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
    .INIT_MODE(INIT_MODE), .BYPASS(BYPASS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .init_req  (init_req),
    .read_reg  (read_reg),
    .read_data (read_data),
    .write_reg (write_reg),
    .write_data(write_data),
    .regwrite  (regwrite),
    .ready     (ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic                ready;
    logic [NRD*XLEN-1:0] rd;
    string               tag;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: register contents plus count of completed init edges.
  logic [XLEN-1:0] m_regs[NREGS];
  int              m_init_edges;
  bit              m_ready;

  // Per-cycle stimulus, packed onto the DUT ports by step().
  logic [AW-1:0]   ra[NRD];
  logic [AW-1:0]   wa[NWR];
  logic [XLEN-1:0] wd[NWR];
  bit              we[NWR];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] init_value(input int i);
    return (INIT_MODE == 1) ? XLEN'(i) : '0;
  endfunction

  task automatic clear_writes();
    for (int p = 0; p < NWR; p++) begin
      we[p] = 1'b0;
      wa[p] = '0;
      wd[p] = '0;
    end
  endtask

  // Drives one cycle: queues the expected pre-edge outputs, advances the model
  // across the edge, then waits for the edge.
  task automatic step(input bit rst, input bit ireq, input string tag);
    exp_t e;
    reset    = rst;
    init_req = ireq;
    for (int k = 0; k < NRD; k++) read_reg[k*AW +: AW] = ra[k];
    for (int p = 0; p < NWR; p++) begin
      write_reg[p*AW +: AW]     = wa[p];
      write_data[p*XLEN +: XLEN] = wd[p];
      regwrite[p]               = we[p];
    end

    e.ready = m_ready;
    e.tag   = tag;
    e.rd    = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [XLEN-1:0] v;
      v = '0;
      if (m_ready && ra[k] != 0) begin
        v = m_regs[ra[k]];
        if (BYPASS == 1)
          for (int p = 0; p < NWR; p++)
            if (we[p] && wa[p] == ra[k]) v = wd[p];
      end
      e.rd[k*XLEN +: XLEN] = v;
    end
    exp_q.push_back(e);

    if (rst) begin
      m_init_edges = 0;
      m_ready      = 1'b0;
    end else if (!m_ready) begin
      m_regs[m_init_edges] = init_value(m_init_edges);
      m_init_edges++;
      if (m_init_edges == NREGS) m_ready = 1'b1;
    end else if (ireq) begin
      m_init_edges = 0;
      m_ready      = 1'b0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (we[p] && wa[p] != 0) m_regs[wa[p]] = wd[p];
    end

    @(posedge clock);
    #1;
  endtask

  // Monitor: outputs are always presented, so compare once per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.tag, " ready"}, XLEN'(ready), XLEN'(e.ready));
        for (int k = 0; k < NRD; k++)
          check($sformatf("%s rd%0d", e.tag, k), read_data[k*XLEN +: XLEN],
                e.rd[k*XLEN +: XLEN]);
      end
    end
  end

  initial begin
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_init_edges = 0;
    m_ready      = 1'b0;
    clear_writes();
    for (int k = 0; k < NRD; k++) ra[k] = '0;
    reset      = 1'b1;
    init_req   = 1'b0;
    read_reg   = '0;
    write_reg  = '0;
    write_data = '0;
    regwrite   = '0;
    @(posedge clock);
    #1;

    // Reset held for a second cycle, then the init sweep.
    step(1'b1, 1'b0, "reset");
    ra[0] = AW'(3);
    ra[1] = AW'(31);
    for (int i = 0; i < NREGS; i++) step(1'b0, 1'b0, "init");
    step(1'b0, 1'b0, "post_init");

    // Single write with same-cycle bypass.
    ra[0] = AW'(2);
    ra[1] = AW'(5);
    we[0] = 1'b1; wa[0] = AW'(2); wd[0] = XLEN'(64'h1000);
    step(1'b0, 1'b0, "wr2");
    clear_writes();
    step(1'b0, 1'b0, "rd2");

    // Port collision: port 1 wins.
    ra[0] = AW'(5);
    we[0] = 1'b1; wa[0] = AW'(5); wd[0] = XLEN'(64'hAAAA);
    we[1] = 1'b1; wa[1] = AW'(5); wd[1] = XLEN'(64'hBBBB);
    step(1'b0, 1'b0, "collide");
    clear_writes();
    step(1'b0, 1'b0, "rd5");

    // Register zero write is dropped.
    ra[0] = AW'(0);
    ra[1] = AW'(2);
    we[1] = 1'b1; wa[1] = AW'(0); wd[1] = XLEN'(64'hFFFF_FFFF);
    step(1'b0, 1'b0, "wr0");
    clear_writes();
    step(1'b0, 1'b0, "rd0");

    // init_req re-runs the sweep; writes during INIT are ignored.
    ra[0] = AW'(2);
    ra[1] = AW'(5);
    step(1'b0, 1'b1, "init_req");
    for (int i = 0; i < NREGS; i++) begin
      we[0] = 1'b1; wa[0] = AW'(2); wd[0] = {$urandom, $urandom};
      we[1] = 1'b1; wa[1] = AW'(5); wd[1] = {$urandom, $urandom};
      step(1'b0, 1'b0, "reinit");
    end
    clear_writes();
    step(1'b0, 1'b0, "post_reinit");

    // Reset at init_cnt == 10 restarts the sweep.
    step(1'b0, 1'b1, "init_req2");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "partial");
    step(1'b1, 1'b0, "mid_reset");
    for (int i = 0; i < NREGS; i++) step(1'b0, 1'b0, "reinit2");
    for (int i = 0; i < NREGS; i += NRD) begin
      for (int k = 0; k < NRD; k++) ra[k] = AW'(i + k);
      step(1'b0, 1'b0, "sweep");
    end

    // Random traffic with occasional re-init and reset.
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      for (int k = 0; k < NRD; k++) ra[k] = AW'($urandom_range(0, NREGS - 1));
      clear_writes();
      if (sel == 0) begin
        step(1'b1, 1'b0, "rnd_reset");
      end else if (sel < 3) begin
        step(1'b0, 1'b1, "rnd_init_req");
      end else begin
        for (int p = 0; p < NWR; p++) begin
          we[p] = 1'($urandom_range(0, 1));
          wa[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                              : AW'($urandom_range(0, NREGS - 1));
          wd[p] = {$urandom, $urandom};
        end
        step(1'b0, 1'b0, "rnd");
      end
    end
    clear_writes();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
